// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the fetch PC, drives the ROM address and
// buffers {pc, instr} pairs in a small FIFO drained by decode.
module fetch_ctrl #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              Q_DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_en,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [15:0]                imem_data,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [15:0]                instr,
  output logic [PC_W-1:0]            instr_pc,
  output logic [$clog2(Q_DEPTH):0]   q_count
);

  localparam int AW = $clog2(Q_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(Q_DEPTH);

  logic [PC_W-1:0] fpc;
  logic [PC_W-1:0] pc_q  [Q_DEPTH];
  logic [15:0]     ins_q [Q_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic push;
  logic pop;
  logic [PC_W-1:0] tgt;
  logic [CW-1:0]   count_nxt;

  assign instr_valid = (count != '0);
  assign instr       = ins_q[rd_ptr];
  assign instr_pc    = pc_q[rd_ptr];
  assign imem_addr   = fpc;
  assign q_count     = count;

  assign pop  = instr_valid & instr_ready;
  assign push = fetch_en & ~redirect_valid & ((count < FULL) | pop);
  // Instructions are halfword aligned; odd targets round down.
  assign tgt  = redirect_pc & ~PC_W'(1);

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < Q_DEPTH; i++) begin
        pc_q[i]  <= '0;
        ins_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      fpc    <= tgt;
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        pc_q[wr_ptr]  <= fpc;
        ins_q[wr_ptr] <= imem_data;
        wr_ptr        <= wr_ptr + AW'(1);
        fpc           <= fpc + PC_W'(2);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, backpressure, redirect,
// drain with fetch disabled and asynchronous reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [1:0]  q_count;

  int total = 0;
  int bad = 0;

  logic [15:0] rom [8];

  always #5 clk = ~clk;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (a < 16'd16) return rom[a[3:1]];
    return ~a;
  endfunction

  assign imem_data = word_at(imem_addr);

  fetch_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_en(fetch_en),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .q_count(q_count)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (q_count > 2'd2) begin
        bad++;
        $display("FAIL overflow q_count=%0d max=2", q_count);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    step();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (instr_valid !== 1'b0 || q_count !== 2'd0 || imem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL reset valid=%b cnt=%0d addr=%h want 0/0/0000",
               instr_valid, q_count, imem_addr);
    end
  endtask

  task automatic test_stream();
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'(2 * i) ||
          instr !== rom[i] || q_count !== 2'd1) begin
        bad++;
        $display("FAIL stream%0d v=%b pc=%h ins=%h cnt=%0d want 1/%h/%h/1",
                 i, instr_valid, instr_pc, instr, q_count, 16'(2 * i), rom[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr !== rom[0]) begin
        bad++;
        $display("FAIL bp_head%0d v=%b pc=%h ins=%h want 1/0000/%h",
                 i, instr_valid, instr_pc, instr, rom[0]);
      end
    end
    total++;
    if (q_count !== 2'd2 || imem_addr !== 16'h0004) begin
      bad++;
      $display("FAIL bp_full cnt=%0d addr=%h want 2/0004", q_count, imem_addr);
    end
    instr_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'(2 * i) ||
          instr !== rom[i] || q_count !== 2'd2) begin
        bad++;
        $display("FAIL bp_release%0d v=%b pc=%h ins=%h cnt=%0d want 1/%h/%h/2",
                 i, instr_valid, instr_pc, instr, q_count, 16'(2 * i), rom[i]);
      end
    end
  endtask

  task automatic test_redirect();
    total++;
    if (q_count !== 2'd2) begin
      bad++;
      $display("FAIL redir_pre cnt=%0d want 2", q_count);
    end
    redirect_valid = 1'b1;
    redirect_pc = 16'h000A;
    step();
    redirect_valid = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || q_count !== 2'd0 || imem_addr !== 16'h000A) begin
      bad++;
      $display("FAIL redir_flush v=%b cnt=%0d addr=%h want 0/0/000a",
               instr_valid, q_count, imem_addr);
    end
    step();
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h000A || instr !== rom[5]) begin
      bad++;
      $display("FAIL redir_target v=%b pc=%h ins=%h want 1/000a/%h",
               instr_valid, instr_pc, instr, rom[5]);
    end
  endtask

  task automatic test_redirect_edges();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0007;
    step();
    redirect_valid = 1'b0;
    total++;
    if (imem_addr !== 16'h0006 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_odd addr=%h v=%b want 0006/0", imem_addr, instr_valid);
    end
    step();
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0006 || instr !== rom[3]) begin
      bad++;
      $display("FAIL redir_odd_tgt v=%b pc=%h ins=%h want 1/0006/%h",
               instr_valid, instr_pc, instr, rom[3]);
    end
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    total++;
    if (imem_addr !== 16'hFFFE || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_top addr=%h v=%b want fffe/0", imem_addr, instr_valid);
    end
    step();
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFE || instr !== 16'h0001) begin
      bad++;
      $display("FAIL wrap_a v=%b pc=%h ins=%h want 1/fffe/0001",
               instr_valid, instr_pc, instr);
    end
    step();
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr !== rom[0]) begin
      bad++;
      $display("FAIL wrap_b v=%b pc=%h ins=%h want 1/0000/%h",
               instr_valid, instr_pc, instr, rom[0]);
    end
  endtask

  task automatic test_drain();
    apply_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b0;
    step();
    step();
    total++;
    if (q_count !== 2'd2 || imem_addr !== 16'h0004) begin
      bad++;
      $display("FAIL drain_full cnt=%0d addr=%h want 2/0004", q_count, imem_addr);
    end
    fetch_en = 1'b0;
    instr_ready = 1'b1;
    step();
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0002 ||
        instr !== rom[1] || q_count !== 2'd1) begin
      bad++;
      $display("FAIL drain_one v=%b pc=%h ins=%h cnt=%0d want 1/0002/%h/1",
               instr_valid, instr_pc, instr, q_count, rom[1]);
    end
    step();
    step();
    total++;
    if (instr_valid !== 1'b0 || q_count !== 2'd0 || imem_addr !== 16'h0004) begin
      bad++;
      $display("FAIL drain_empty v=%b cnt=%0d addr=%h want 0/0/0004",
               instr_valid, q_count, imem_addr);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b0;
    step();
    step();
    total++;
    if (q_count !== 2'd2) begin
      bad++;
      $display("FAIL areset_pre cnt=%0d want 2", q_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || q_count !== 2'd0 || imem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL areset v=%b cnt=%0d addr=%h want 0/0/0000",
               instr_valid, q_count, imem_addr);
    end
    step();
    fetch_en = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rom[0] = 16'h1234; rom[1] = 16'h2345;
    rom[2] = 16'h3456; rom[3] = 16'h4567;
    rom[4] = 16'h5678; rom[5] = 16'h6789;
    rom[6] = 16'h789A; rom[7] = 16'h89AB;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_edges();
    test_drain();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller that sequences the program counter into the combinational instruction ROM and buffers fetched words for decode. It sits between the PC/branch logic and the ROM: it owns the fetch PC, presents the ROM address, and captures each {pc, instruction} pair into a small FIFO. Decode drains the FIFO over a valid/ready handshake, and taken branches redirect and flush it.

## Interface
- PC_W, 16: PC and address width.
- RESET_PC, 16'h0000: fetch PC loaded at reset.
- Q_DEPTH, 2: fetch FIFO entries; power of two, ≥2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  permits new fetches when high; does not gate the pop handshake.
- imem_addr  out  PC_W  ROM address; always equals the fetch PC register.
- imem_data  in  16  ROM word for imem_addr, valid in the same cycle (combinational ROM).
- redirect_valid  in  1  branch/jump redirect request, single-cycle pulse.
- redirect_pc  in  PC_W  redirect target.
- instr_valid  out  1  FIFO head holds a valid entry.
- instr_ready  in  1  decode accepts the head entry.
- instr  out  16  head instruction word.
- instr_pc  out  PC_W  PC of the head instruction.
- q_count  out  clog2(Q_DEPTH)+1  current FIFO occupancy.

## Operation
- State is held in registers: fpc, FIFO storage, rd/wr pointers, and count.
- Registers update on the rising edge of clk, or asynchronously on the falling edge of rst_n.
- pop = instr_valid & instr_ready.
- push = fetch_en & ~redirect_valid & (count < Q_DEPTH | pop).
  - Push writes {fpc, imem_data} at wr_ptr.
  - On push, fpc ← fpc + 2, modulo 2^PC_W: 16'hFFFE wraps to 16'h0000.
- Redirect has priority over everything else in its cycle:
  - FIFO flushed: count ← 0, rd_ptr ← wr_ptr.
  - fpc ← {redirect_pc[PC_W-1:1], 1'b0}; odd targets are forced even.
  - No push occurs.
  - Any pop in the same cycle is still seen by decode, but does not alter state beyond the flush.
- Simultaneous push and pop: count unchanged. This is allowed when full, so the FIFO can sustain one instruction per cycle.
- fetch_en low: fpc holds, no push, pops continue until the FIFO is empty.
- instr, instr_pc and instr_valid are driven directly from the FIFO head and count. There is no combinational path from imem_data to instr.
- instr and instr_pc are don't-care when instr_valid = 0; the bench compares them only when valid.
- Pointers wrap modulo Q_DEPTH.
- count never exceeds Q_DEPTH. Overflow is a design bug; the bench asserts against it.

## Timing
- Reset values:
  - fpc = RESET_PC, so imem_addr = RESET_PC.
  - count = 0, q_count = 0, instr_valid = 0.
  - Pointers = 0; FIFO contents cleared to 0.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Fetch latency: the ROM word at fpc is captured at edge N and is visible on instr/instr_valid after edge N.
- After reset release, the first edge with fetch_en = 1 makes instr_valid = 1 with instr_pc = RESET_PC.
- Redirect at edge N:
  - After N: instr_valid = 0, imem_addr = target.
  - After N+1: target instruction valid.
  - Cost is exactly one bubble cycle.
- Steady state with instr_ready held high: one instruction per cycle, PCs consecutive by +2.
- Backpressure (instr_ready = 0): the FIFO fills to Q_DEPTH after Q_DEPTH push edges, then fpc stalls.
  - Head entry, instr and instr_pc remain stable while instr_valid = 1 and instr_ready = 0.

## Test plan
- Reset then fetch_en = 1, instr_ready = 1, ROM preloaded with 8 words → instr_pc sequence 0,2,4,…,14 on consecutive cycles, instr = rom[pc>>1], q_count stays 1.
- instr_ready = 0 for 5 cycles → q_count reaches 2 and holds, imem_addr frozen at 4, head stays pc 0. Release instr_ready → pcs 0,2,4 emitted back-to-back with no gap.
- redirect_valid with redirect_pc = 16'h000A while FIFO holds 2 entries → next cycle instr_valid = 0, q_count = 0, imem_addr = 0x000A. Following cycle instr_pc = 0x000A.
- Redirect to 16'h0007 (odd) → fetch resumes at 0x0006. Redirect to 16'hFFFE → instr_pc sequence 0xFFFE then 0x0000.
- fetch_en dropped with FIFO full and instr_ready = 1 → 2 remaining instructions drain, then instr_valid = 0 and imem_addr unchanged.
- rst_n asserted asynchronously mid-cycle while q_count = 2 → instr_valid, q_count and imem_addr change to 0/0/RESET_PC before the next clock edge.
